// File: rtl/i2s_rx_frame_assembler.sv
// I2S receive frame assembler: pairs L/R sample words into frames, reduces them to OUT_WIDTH and queues them in a 2-deep FWFT FIFO.
// Optional macro RX_FRAME_ROUND_EN selects round-half-up with saturation and adds one input pipeline stage.
module i2s_rx_frame_assembler #(
  parameter int   IN_WIDTH  = 24,
  parameter int   OUT_WIDTH = 16,
  parameter logic WS_LEFT   = 1'b0
) (
  input  logic                 lmmi_clk_i,
  input  logic                 reset_n_i,
  input  logic                 conf_en_i,
  input  logic [31:0]          sample_dat_i,
  input  logic                 sample_vld_i,
  input  logic                 ws_i,
  output logic [OUT_WIDTH-1:0] frm_left_o,
  output logic [OUT_WIDTH-1:0] frm_right_o,
  output logic                 frm_vld_o,
  input  logic                 frm_rdy_i,
  output logic                 sync_err_o,
  output logic                 ovf_o,
  output logic [7:0]           drop_cnt_o,
  input  logic                 clr_i
);

  localparam int SH = IN_WIDTH - OUT_WIDTH;

  typedef enum logic {WAIT_L = 1'b0, WAIT_R = 1'b1} state_t;

  logic [IN_WIDTH-1:0]  dat_in;
  logic [OUT_WIDTH-1:0] dat_red;
  logic                 unused_bits;

  assign dat_in = sample_dat_i[IN_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Sample width reduction
  // ---------------------------------------------------------------------------
`ifdef RX_FRAME_ROUND_EN
  localparam logic [IN_WIDTH:0] RND_BIAS = (IN_WIDTH+1)'(1) << (SH-1);

  logic [IN_WIDTH:0]  rnd_sum;
  logic [OUT_WIDTH:0] rnd_q;

  always_comb begin
    rnd_sum = {dat_in[IN_WIDTH-1], dat_in} + RND_BIAS;
    rnd_q   = rnd_sum[IN_WIDTH -: OUT_WIDTH+1];
    // The two top bits disagree only when the rounded value left the output range.
    if (rnd_q[OUT_WIDTH] != rnd_q[OUT_WIDTH-1])
      dat_red = rnd_q[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      dat_red = rnd_q[OUT_WIDTH-1:0];
  end

  assign unused_bits = ^{sample_dat_i[31:IN_WIDTH], rnd_sum[SH-1:0]};

  logic                 wrd_vld_d, wrd_vld_q;
  logic                 wrd_ws_d,  wrd_ws_q;
  logic [OUT_WIDTH-1:0] wrd_dat_d, wrd_dat_q;

  always_comb begin
    wrd_vld_d = conf_en_i & sample_vld_i;
    wrd_ws_d  = ws_i;
    wrd_dat_d = dat_red;
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrd_vld_q <= 1'b0;
      wrd_ws_q  <= 1'b0;
      wrd_dat_q <= '0;
    end else begin
      wrd_vld_q <= wrd_vld_d;
      wrd_ws_q  <= wrd_ws_d;
      wrd_dat_q <= wrd_dat_d;
    end
  end

  logic                 wrd_vld;
  logic                 wrd_ws;
  logic [OUT_WIDTH-1:0] wrd_dat;
  assign wrd_vld = wrd_vld_q;
  assign wrd_ws  = wrd_ws_q;
  assign wrd_dat = wrd_dat_q;
`else
  assign dat_red     = dat_in[IN_WIDTH-1 -: OUT_WIDTH];
  assign unused_bits = ^{sample_dat_i[31:IN_WIDTH], dat_in[SH-1:0]};

  logic                 wrd_vld;
  logic                 wrd_ws;
  logic [OUT_WIDTH-1:0] wrd_dat;
  assign wrd_vld = sample_vld_i;
  assign wrd_ws  = ws_i;
  assign wrd_dat = dat_red;
`endif

  logic wrd_is_left;
  assign wrd_is_left = (wrd_ws == WS_LEFT);

  // ---------------------------------------------------------------------------
  // L/R pairing FSM
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic [OUT_WIDTH-1:0] held_l_q;

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= WAIT_L;
      held_l_q <= '0;
    end else if (!conf_en_i) begin
      state_q  <= WAIT_L;
      held_l_q <= '0;
    end else if (wrd_vld) begin
      case (state_q)
        WAIT_L: if (wrd_is_left) begin
          held_l_q <= wrd_dat;
          state_q  <= WAIT_R;
        end
        // A second left word replaces the held one; the old left is lost.
        WAIT_R: if (wrd_is_left) held_l_q <= wrd_dat;
                else             state_q  <= WAIT_L;
        default: state_q <= WAIT_L;
      endcase
    end
  end

  logic push;
  logic sync_drop;

  always_comb begin
    push      = 1'b0;
    sync_drop = 1'b0;
    if (wrd_vld) begin
      case (state_q)
        WAIT_L: sync_drop = ~wrd_is_left;
        WAIT_R: begin
          push      = ~wrd_is_left;
          sync_drop = wrd_is_left;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry FWFT FIFO (head drives the outputs directly) and status
  // ---------------------------------------------------------------------------
  logic [1:0]           cnt_d,    cnt_q;
  logic [OUT_WIDTH-1:0] head_l_d, head_l_q;
  logic [OUT_WIDTH-1:0] head_r_d, head_r_q;
  logic [OUT_WIDTH-1:0] tail_l_d, tail_l_q;
  logic [OUT_WIDTH-1:0] tail_r_d, tail_r_q;
  logic                 vld_d,    vld_q;
  logic                 err_d,    err_q;
  logic                 ovf_d,    ovf_q;
  logic [7:0]           drop_d,   drop_q;
  logic                 pop;
  logic                 ovf_set;

  assign pop = vld_q & frm_rdy_i;

  always_comb begin
    cnt_d    = cnt_q;
    head_l_d = head_l_q;
    head_r_d = head_r_q;
    tail_l_d = tail_l_q;
    tail_r_d = tail_r_q;
    ovf_set  = 1'b0;
    case ({push, pop})
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_l_d = tail_l_q;
          head_r_d = tail_r_q;
          cnt_d    = 2'd1;
        end else begin
          head_l_d = '0;
          head_r_d = '0;
          cnt_d    = 2'd0;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_l_d = held_l_q;
          head_r_d = wrd_dat;
          cnt_d    = 2'd1;
        end else if (cnt_q == 2'd1) begin
          tail_l_d = held_l_q;
          tail_r_d = wrd_dat;
          cnt_d    = 2'd2;
        end else begin
          ovf_set  = 1'b1;
        end
      end
      // Simultaneous push/pop always fits, even when full.
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_l_d = tail_l_q;
          head_r_d = tail_r_q;
          tail_l_d = held_l_q;
          tail_r_d = wrd_dat;
        end else begin
          head_l_d = held_l_q;
          head_r_d = wrd_dat;
        end
      end
      default: ;
    endcase
    vld_d = (cnt_d != 2'd0);

    err_d  = err_q | sync_drop;
    ovf_d  = ovf_q | ovf_set;
    drop_d = ((sync_drop | ovf_set) && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    if (clr_i) begin
      err_d  = 1'b0;
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end

    if (!conf_en_i) begin
      cnt_d    = 2'd0;
      head_l_d = '0;
      head_r_d = '0;
      tail_l_d = '0;
      tail_r_d = '0;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
      drop_d   = 8'd0;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= 2'd0;
      head_l_q <= '0;
      head_r_q <= '0;
      tail_l_q <= '0;
      tail_r_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      cnt_q    <= cnt_d;
      head_l_q <= head_l_d;
      head_r_q <= head_r_d;
      tail_l_q <= tail_l_d;
      tail_r_q <= tail_r_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign frm_left_o  = head_l_q;
  assign frm_right_o = head_r_q;
  assign frm_vld_o   = vld_q;
  assign sync_err_o  = err_q;
  assign ovf_o       = ovf_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_i2s_rx_frame_assembler.sv
// Bench for i2s_rx_frame_assembler: directed steps plus random traffic against a queue-based reference model.
module tb_i2s_rx_frame_assembler;

`ifdef RX_FRAME_ROUND_EN
  localparam int LAT = 2;
  localparam logic [15:0] PAIR_R = 16'hFEDD;
  localparam logic [15:0] RED1 = 16'h7FFF, RED2 = 16'h0001, RED3 = 16'h0000;
`else
  localparam int LAT = 1;
  localparam logic [15:0] PAIR_R = 16'hFEDC;
  localparam logic [15:0] RED1 = 16'h7FFF, RED2 = 16'h0000, RED3 = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n, conf_en, vld, ws, rdy, clr;
  logic [31:0] dat;
  logic [15:0] fl, fr;
  logic        fv, serr, ovf;
  logic [7:0]  dcnt;

  i2s_rx_frame_assembler dut (
    .lmmi_clk_i(clk), .reset_n_i(rst_n), .conf_en_i(conf_en),
    .sample_dat_i(dat), .sample_vld_i(vld), .ws_i(ws),
    .frm_left_o(fl), .frm_right_o(fr), .frm_vld_o(fv), .frm_rdy_i(rdy),
    .sync_err_o(serr), .ovf_o(ovf), .drop_cnt_o(dcnt), .clr_i(clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mq_l[$];
  int mq_r[$];
  bit m_have_l;
  int m_held;
  bit p_v, p_ws;
  int p_dat;
  bit m_err, m_ovf;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int red(input int raw);
    int v;
    v = raw & 'hFFFFFF;
    if (v >= 'h800000) v = v - 'h1000000;
`ifdef RX_FRAME_ROUND_EN
    v = (v + 128) >>> 8;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
`else
    v = v >>> 8;
`endif
    return v & 'hFFFF;
  endfunction

  task automatic model_clear();
    mq_l.delete(); mq_r.delete();
    m_have_l = 0; m_held = 0;
    p_v = 0; p_ws = 0; p_dat = 0;
    m_err = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit wv, wws, pop, push, s_err, s_drop;
    int wd, pl, pr;
    if (!conf_en) begin model_clear(); return; end
    if (LAT == 2) begin
      wv = p_v; wws = p_ws; wd = p_dat;
      p_v = vld; p_ws = ws; p_dat = int'(dat[23:0]);
    end else begin
      wv = vld; wws = ws; wd = int'(dat[23:0]);
    end
    pop = (mq_l.size() > 0) && rdy;
    push = 0; s_err = 0; s_drop = 0; pl = 0; pr = 0;
    if (wv) begin
      if (wws == 1'b0) begin
        if (m_have_l) s_err = 1;
        m_have_l = 1; m_held = red(wd);
      end else if (!m_have_l) begin
        s_err = 1;
      end else begin
        push = 1; pl = m_held; pr = red(wd); m_have_l = 0;
      end
    end
    if (pop) begin void'(mq_l.pop_front()); void'(mq_r.pop_front()); end
    if (push) begin
      if (mq_l.size() == 2) s_drop = 1;
      else begin mq_l.push_back(pl); mq_r.push_back(pr); end
    end
    if (clr) begin
      m_err = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (s_err) m_err = 1;
      if (s_drop) m_ovf = 1;
      if ((s_err || s_drop) && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic compare_all();
    chk("frm_vld", fv, mq_l.size() > 0);
    if (mq_l.size() > 0) begin
      chk("frm_left", fl, mq_l[0]);
      chk("frm_right", fr, mq_r[0]);
    end
    chk("sync_err", serr, m_err);
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", dcnt, m_cnt);
  endtask

  task automatic step(input bit v, input bit w, input logic [23:0] d,
                      input bit r, input bit c, input bit e);
    vld = v; ws = w; dat = {8'($urandom), d}; rdy = r; clr = c; conf_en = e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit r);
    step(0, 0, 24'h0, r, 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, fv, 0);
    chk({tag, "_left"}, fl, 0);
    chk({tag, "_right"}, fr, 0);
    chk({tag, "_err"}, serr, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_cnt"}, dcnt, 0);
  endtask

  task automatic do_reset();
    vld = 0; clr = 0; conf_en = 1;
    rst_n = 0;
    #1;
    model_clear();
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit nws, v, w;
    logic [23:0] bl, br;
    rst_n = 0; conf_en = 1; vld = 0; ws = 0; dat = 0; rdy = 0; clr = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // basic pair
    step(1, 0, 24'h123456, 1, 0, 1);
    step(1, 1, 24'hFEDCBA, 1, 0, 1);
    if (LAT == 2) idle(1);
    chk("pair_vld", fv, 1);
    chk("pair_left", fl, 16'h1234);
    chk("pair_right", fr, PAIR_R);
    idle(1);
    chk("pair_one_cycle", fv, 0);

    // backpressure: three frames into a 2-deep FIFO
    for (int i = 0; i < 3; i++) begin
      bl = 24'(((i + 1) << 20) | 'h11100);
      br = 24'(((i + 1) << 20) | 'h22200);
      step(1, 0, bl, 0, 0, 1);
      step(1, 1, br, 0, 0, 1);
    end
    repeat (LAT) idle(0);
    chk("bp_ovf", ovf, 1);
    chk("bp_cnt", dcnt, 1);
    chk("bp_head", fl, 16'h1111);
    idle(0);
    chk("bp_stable", fl, 16'h1111);
    idle(1);
    chk("bp_pop2", fl, 16'h2111);
    idle(1);
    chk("bp_empty", fv, 0);
    step(0, 0, 24'h0, 0, 1, 1);
    chk("bp_clr_ovf", ovf, 0);

    // sync error: A, B (both left) then C
    step(1, 0, 24'hAAAA00, 0, 0, 1);
    step(1, 0, 24'hBBBB00, 0, 0, 1);
    step(1, 1, 24'hCCCC00, 0, 0, 1);
    repeat (LAT) idle(0);
    chk("se_err", serr, 1);
    chk("se_cnt", dcnt, 1);
    chk("se_left", fl, 16'hBBBB);
    chk("se_right", fr, 16'hCCCC);
    idle(1);
    step(0, 0, 24'h0, 0, 1, 1);

    // full boundary: push and pop in the same cycle
    step(1, 0, 24'h310000, 0, 0, 1); step(1, 1, 24'h320000, 0, 0, 1);
    step(1, 0, 24'h410000, 0, 0, 1); step(1, 1, 24'h420000, 0, 0, 1);
    step(1, 0, 24'h510000, 0, 0, 1); step(1, 1, 24'h520000, LAT == 1, 0, 1);
    if (LAT == 2) idle(1);
    chk("fb_ovf", ovf, 0);
    chk("fb_head", fl, 16'h4100);
    idle(1);
    chk("fb_next", fl, 16'h5100);
    chk("fb_next_vld", fv, 1);
    idle(1);
    chk("fb_empty", fv, 0);

    // reset while holding a left sample
    step(1, 0, 24'h600000, 1, 0, 1);
    do_reset();
    step(1, 1, 24'h610000, 1, 0, 1);
    repeat (LAT + 1) idle(0);
    chk("rst_noframe", fv, 0);
    step(0, 0, 24'h0, 0, 1, 1);

    // enable low while holding a left sample and a queued frame
    step(1, 1, 24'h6F0000, 0, 0, 1);
    step(1, 0, 24'h700000, 0, 0, 1); step(1, 1, 24'h710000, 0, 0, 1);
    step(1, 0, 24'h720000, 0, 0, 1);
    repeat (LAT) idle(0);
    chk("en_pre_vld", fv, 1);
    step(0, 0, 24'h0, 0, 0, 0);
    chk_zero("en_flush");
    step(1, 1, 24'h730000, 1, 0, 1);
    repeat (LAT + 1) idle(0);
    chk("en_noframe", fv, 0);
    step(0, 0, 24'h0, 0, 1, 1);

    // reduction corner values
    step(1, 0, 24'h7FFFFF, 0, 0, 1); step(1, 1, 24'h000080, 0, 0, 1);
    step(1, 0, 24'hFFFF80, 0, 0, 1); step(1, 1, 24'hFFFF80, 0, 0, 1);
    repeat (LAT) idle(0);
    chk("red_7fffff", fl, RED1);
    chk("red_000080", fr, RED2);
    idle(1);
    chk("red_ffff80", fl, RED3);
    idle(1);
    idle(1);

    // drop counter saturation
    for (int i = 0; i < 300; i++) step(1, 1, 24'($urandom), 1, 0, 1);
    chk("sat_cnt", dcnt, 8'hFF);
    chk("sat_err", serr, 1);
    step(0, 0, 24'h0, 1, 1, 1);
    chk("sat_clr_cnt", dcnt, 0);
    chk("sat_clr_err", serr, 0);
    chk("sat_clr_ovf", ovf, 0);

    // random traffic
    nws = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      v = ($urandom_range(2) == 0);
      w = ($urandom_range(9) == 0) ? ~nws : nws;
      if (v) nws = ~w;
      step(v, w, 24'($urandom), $urandom_range(2) == 0,
           $urandom_range(49) == 0, $urandom_range(99) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
